// File: rtl/div_digit_pkg.sv
// Shared types and sizes for the divider digit-frame controller.
package div_digit_pkg;

  localparam int DIGIT_W    = 2;
  localparam int DIG_ADDR_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/div_digit_skid2.sv
// Two-entry shift FIFO used as the drain output buffer. Entry 0 is always
// the head, so the head data leaves straight from flops.
module div_digit_skid2 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;

  // Next-state for the two slots; a pop shifts slot 1 forward.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != 2'd0);
    case ({push_i, do_pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = push_data_i;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          slot1_d = push_data_i;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = push_data_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = slot0_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/div_digit_frame_ctrl.sv
// Frame controller around the divider digit RAM: fills a frame from the
// divider stream, drains it forward or reversed through a 2-entry buffer
// that hides the registered RAM read, then clears the RAM.
module div_digit_frame_ctrl
  import div_digit_pkg::*;
#(
  parameter int DATA_WIDTH = DIGIT_W,
  parameter int ADDR_WIDTH = DIG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   frame_len,
  input  logic                  rev,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_digit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_digit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_we,
  output logic                  ram_clear,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  dir_q, dir_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic [ADDR_WIDTH:0]   rcnt_q, rcnt_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_last_q, infl_last_d;
  logic                  ram_clear_q;

  logic [DATA_WIDTH:0]   fifo_head;
  logic                  fifo_valid;
  logic [1:0]            fifo_count;

  logic                  wr_acc, wr_last, rd_last, issue, pop;
  logic [2:0]            occ;

  // Read data returns one cycle after issue and is tagged with its last flag.
  div_digit_skid2 #(
    .W (DATA_WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i ({infl_last_q, ram_q}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  // Next-state, counters and read-issue decision.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dir_d   = dir_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;

    pop     = fifo_valid && out_ready;
    wr_acc  = in_valid && (state_q == FILL);
    wr_last = (wcnt_q == len_q - (ADDR_WIDTH+1)'(1));
    rd_last = (rcnt_q == len_q - (ADDR_WIDTH+1)'(1));
    // Occupancy counts both buffered digits and the read still in the RAM;
    // a same-cycle pop frees one slot for a new read.
    occ     = {1'b0, fifo_count} + {2'b00, inflight_q};
    issue   = (state_q == DRAIN) && (rcnt_q != len_q) &&
              (occ < (3'd2 + {2'b00, pop}));

    inflight_d  = issue;
    infl_last_d = issue && rd_last;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          len_d   = (frame_len == '0) ? MAX_LEN : frame_len;
          dir_d   = rev;
          wcnt_d  = '0;
          rcnt_d  = '0;
          waddr_d = '0;
        end
      end
      FILL: begin
        if (wr_acc) begin
          wcnt_d = wcnt_q + (ADDR_WIDTH+1)'(1);
          if (wr_last) begin
            state_d = DRAIN;
            // Reverse drains start at len-1; for a full frame this wraps to the top address.
            raddr_d = dir_q ? (len_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1)) : '0;
          end else begin
            waddr_d = waddr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (issue) begin
          rcnt_d = rcnt_q + (ADDR_WIDTH+1)'(1);
          // Hold the address after the final read so it never leaves 0..len-1.
          if (!rd_last) begin
            raddr_d = dir_q ? (raddr_q - ADDR_WIDTH'(1)) : (raddr_q + ADDR_WIDTH'(1));
          end
        end
        if (pop && fifo_head[DATA_WIDTH]) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      dir_q       <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      ram_clear_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      dir_q       <= dir_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      ram_clear_q <= (state_d == CLEAR);
    end
  end

  assign in_ready       = (state_q == FILL);
  assign ram_we         = in_valid && in_ready;
  assign ram_data       = in_digit;
  assign ram_write_addr = waddr_q;
  assign ram_read_addr  = raddr_q;
  assign ram_clear      = ram_clear_q;
  assign busy           = (state_q != IDLE);
  assign out_digit      = fifo_head[DATA_WIDTH-1:0];
  assign out_valid      = fifo_valid;
  assign out_last       = fifo_valid && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_div_digit_frame_ctrl.sv
// Bench for the digit-frame controller with a behavioural RAM alongside it.
module tb_div_digit_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] frame_len;
  logic       rev;
  logic       start;
  logic [1:0] in_digit;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_digit;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic [1:0] ram_data;
  logic [6:0] ram_write_addr;
  logic [6:0] ram_read_addr;
  logic       ram_we;
  logic       ram_clear;
  logic [1:0] ram_q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] mem [0:127];

  always #5 clk = ~clk;

  div_digit_frame_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .frame_len      (frame_len),
    .rev            (rev),
    .start          (start),
    .in_digit       (in_digit),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_digit      (out_digit),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .ram_data       (ram_data),
    .ram_write_addr (ram_write_addr),
    .ram_read_addr  (ram_read_addr),
    .ram_we         (ram_we),
    .ram_clear      (ram_clear),
    .ram_q          (ram_q)
  );

  // Digit RAM with registered read address and a whole-array clear.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 128; i++) mem[i] <= 2'd0;
    end else if (ram_we) begin
      mem[ram_write_addr] <= ram_data;
    end
    ram_q <= mem[ram_read_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: n digits (1..128), order r, write-gap and stall percentages,
  // optional start held high throughout, optional reset after abort_after pops,
  // dmode 0 random digits, 1 (i+1)%4, 2 i%4.
  task automatic run_frame(input int n, input bit r, input int gap_pct, input int stall_pct,
                           input bit hold_start, input int abort_after, input int dmode);
    logic [1:0] wq[$];
    logic [1:0] exp_q[$];
    int written, popped, cyc, first_cyc;
    bit first_seen, stalled_prev;
    logic [1:0] held_d;
    logic held_l;

    chk("idle_busy", busy, 0);
    frame_len = (n == 128) ? 8'd0 : 8'(n);
    rev       = r;
    start     = 1'b1;
    step();
    chk("fill_busy", busy, 1);
    if (hold_start) begin
      frame_len = 8'($urandom_range(1, 127));
      rev       = ~r;
    end else begin
      start = 1'b0;
    end

    written = 0;
    cyc     = 0;
    while (written < n && cyc < 4000) begin
      chk("in_ready_fill", in_ready, 1);
      in_valid = (int'($urandom_range(99)) >= gap_pct);
      if (dmode == 1)      in_digit = 2'((written + 1) % 4);
      else if (dmode == 2) in_digit = 2'(written % 4);
      else                 in_digit = 2'($urandom_range(3));
      #1;
      chk("ram_we", ram_we, in_valid);
      if (in_valid) begin
        chk("waddr", ram_write_addr, written);
        chk("ram_data", ram_data, in_digit);
        wq.push_back(in_digit);
        written++;
      end
      step();
      cyc++;
    end
    chk("fill_count", written, n);
    in_valid = 1'b0;

    for (int i = 0; i < wq.size(); i++) exp_q.push_back(r ? wq[wq.size() - 1 - i] : wq[i]);

    chk("in_ready_drain", in_ready, 0);
    popped = 0; cyc = 0; first_seen = 0; stalled_prev = 0; first_cyc = 0;
    held_d = 2'd0; held_l = 1'b0;
    while (popped < n && cyc < 4000) begin
      if (abort_after > 0 && popped == abort_after) begin
        out_ready = 1'b0;
        start     = 1'b0;
        reset     = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_last", out_last, 0);
        chk("abort_inready", in_ready, 0);
        chk("abort_clear", ram_clear, 1);
        reset = 1'b0;
        $display("[TB] frame n=%0d rev=%0d aborted after %0d pops", n, r, popped);
        return;
      end
      chk("drain_we", ram_we, 0);
      chk("raddr_range", (ram_read_addr < n) ? 1 : 0, 1);
      if (stalled_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_digit", out_digit, held_d);
        chk("hold_last", out_last, held_l);
      end
      if (out_valid === 1'b1 && !first_seen) begin
        first_seen = 1;
        first_cyc  = cyc;
        chk("first_latency", first_cyc, 2);
      end
      out_ready = (int'($urandom_range(99)) >= stall_pct);
      stalled_prev = 0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          chk("out_digit", out_digit, exp_q[popped]);
          chk("out_last", out_last, (popped == n - 1) ? 1 : 0);
          popped++;
        end else begin
          stalled_prev = 1;
          held_d = out_digit;
          held_l = out_last;
        end
      end
      step();
      cyc++;
    end
    chk("drain_count", popped, n);
    if (stall_pct == 0) chk("throughput", cyc, n + 2);
    out_ready = 1'b0;

    chk("clear_pulse", ram_clear, 1);
    chk("clear_busy", busy, 1);
    chk("clear_valid", out_valid, 0);
    step();
    chk("idle_clear", ram_clear, 0);
    chk("idle_after", busy, 0);
    start = 1'b0;
    step();
    chk("idle_stays", busy, 0);
    chk("idle_inready", in_ready, 0);
    $display("[TB] frame n=%0d rev=%0d gap=%0d stall=%0d hold=%0d popped=%0d",
             n, r, gap_pct, stall_pct, hold_start, popped);
  endtask

  initial begin
    reset = 1'b1; frame_len = 8'd0; rev = 1'b0; start = 1'b0;
    in_digit = 2'd0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_inready", in_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_clear", ram_clear, 1);
    reset = 1'b0;
    step();
    chk("rst_clear_done", ram_clear, 0);
    $display("[TB] reset checked");

    run_frame(4,   1'b0, 0,  0,  1'b0, 0, 1);   // forward 1,2,3,0
    run_frame(5,   1'b1, 40, 0,  1'b0, 0, 0);   // reverse with write gaps
    run_frame(6,   1'b0, 0,  60, 1'b0, 0, 0);   // backpressure
    run_frame(128, 1'b0, 0,  0,  1'b0, 0, 2);   // full frame, digit = addr mod 4
    run_frame(8,   1'b0, 0,  0,  1'b0, 3, 0);   // reset mid-drain
    run_frame(7,   1'b1, 0,  0,  1'b0, 0, 0);   // clean frame after reset
    run_frame(9,   1'b1, 20, 30, 1'b1, 0, 0);   // start held high throughout
    run_frame(1,   1'b0, 0,  0,  1'b0, 0, 0);
    run_frame(1,   1'b1, 0,  50, 1'b1, 0, 0);
    run_frame(128, 1'b1, 10, 30, 1'b0, 0, 0);   // full reverse frame
    for (int k = 0; k < 6; k++) begin
      run_frame(int'($urandom_range(1, 20)), 1'($urandom_range(1)),
                int'($urandom_range(0, 50)), int'($urandom_range(0, 60)),
                1'($urandom_range(1)), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_digit_frame_ctrl.md
Name: div_digit_frame_ctrl

Overview:
- Control stage that wraps the 2-bit x 128 digit RAM used by the divider datapath.
- Accepts a frame of 2-bit quotient digits from the divider over a valid/ready stream and generates the RAM write port.
- Once the frame is complete, reads the digits back in forward or reverse order, absorbing the RAM's 1-cycle registered-address read latency, and presents them as a valid/ready output stream.
- Clears the RAM between frames.

Parameters:
- DATA_WIDTH, 2, digit width; must match the RAM.
- ADDR_WIDTH, 7, RAM address width; maximum frame length is 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_len  in  ADDR_WIDTH+1  digits per frame, 1..2**ADDR_WIDTH; sampled in IDLE when start=1.
- rev  in  1  drain order: 0 = address 0 upward, 1 = address len-1 downward; sampled with frame_len.
- start  in  1  begin a frame (IDLE only; ignored elsewhere).
- in_digit  in  DATA_WIDTH  digit from the divider.
- in_valid  in  1  in_digit valid.
- in_ready  out  1  high only in FILL.
- out_digit  out  DATA_WIDTH  drained digit.
- out_valid  out  1  out_digit valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  qualifies the final digit of the frame.
- busy  out  1  state != IDLE.
- ram_data  out  DATA_WIDTH  RAM data; equals in_digit.
- ram_write_addr  out  ADDR_WIDTH  RAM write address.
- ram_read_addr  out  ADDR_WIDTH  RAM read address.
- ram_we  out  1  in_valid & in_ready.
- ram_clear  out  1  registered one-cycle pulse to the RAM clear input.
- ram_q  in  DATA_WIDTH  RAM output; valid 1 cycle after ram_read_addr is sampled.

Behaviour:
- Reset (synchronous, dominant over all other inputs, including mid-frame):
  - State goes to IDLE and all counters clear.
  - out_valid=0, out_last=0, in_ready=0, ram_we=0, busy=0.
  - ram_clear=1 for exactly the cycle after reset is sampled, so any partial frame is discarded.
- IDLE -> FILL:
  - Transition occurs on start=1.
  - Latch len=frame_len and dir=rev.
  - frame_len=0 is treated as 2**ADDR_WIDTH.
- FILL:
  - in_ready=1.
  - ram_write_addr = wcnt, counting from 0.
  - Each in_valid cycle writes a digit and increments wcnt.
  - When the write with wcnt=len-1 is accepted, go to DRAIN the next cycle.
  - No combinational path from in_valid to in_ready.
- DRAIN:
  - Read address sequence is 0..len-1 when dir=0, and len-1..0 when dir=1.
  - A read issued at cycle t returns ram_q at cycle t+1 and is captured into a 2-entry output FIFO.
  - Issue rule: issue a read at cycle t iff remaining reads > 0 and (fifo_count + inflight - pop_t) < 2, where pop_t = out_valid & out_ready.
  - With out_ready held high, throughput is 1 digit/cycle.
  - The first out_valid appears 2 cycles after entering DRAIN.
  - out_digit, out_valid and out_last come from the FIFO head, so they are registered outputs.
  - out_last=1 on the len-th digit.
  - out_digit and out_last stay stable while out_valid=1 and out_ready=0.
  - Go to CLEAR on the cycle the last digit is popped.
- CLEAR:
  - ram_clear=1 for one cycle, then go to IDLE.
  - A start in this cycle is ignored.
- Boundary cases:
  - len=1 gives a single digit with out_last=1.
  - len=128: address counter wraps only at the end of the frame; wcnt is ADDR_WIDTH+1 bits wide.
  - Reverse drain starts at address len-1, not 127.
  - Address counters never go below 0 or above len-1.
  - ram_write_addr and ram_read_addr hold their last value when unused.

Decomposition:
- Package div_digit_pkg holds:
  - the state enum IDLE/FILL/DRAIN/CLEAR;
  - DIGIT_W=2, DIG_ADDR_W=7.
- One sub-module, div_digit_skid2: a 2-entry DATA_WIDTH+1-bit FIFO (digit plus last flag) with count output, used as the drain output buffer.
- The controller does not instantiate the RAM; the top level connects both.

Test Plan:
- Forward frame:
  - Stimulus: start with frame_len=4, rev=0; write 1,2,3,0; out_ready=1.
  - Response: out_digit 1,2,3,0 on consecutive cycles, first 2 cycles after DRAIN entry; out_last only on 0; ram_clear pulse follows.
- Reverse frame with gaps:
  - Stimulus: frame_len=5, rev=1; digits 0,1,2,3,1 with in_valid gaps.
  - Response: output 1,3,2,1,0; ram_we only on valid cycles; ram_write_addr 0..4.
- Backpressure:
  - Stimulus: len=6, with out_ready toggling 1,0,0,1,...
  - Response: no digit lost or duplicated; outputs stable while stalled; FIFO never exceeds 2.
- Full frame:
  - Stimulus: frame_len=0 (meaning 128), with digits = address mod 4.
  - Response: 128 digits in order; out_last on the 128th; DRAIN entered only after write address 127.
- Reset mid-frame:
  - Stimulus: assert reset during DRAIN after 3 of 8 pops.
  - Response: next cycle busy=0, out_valid=0, ram_clear=1; a new frame then drains cleanly.
- Ignored start:
  - Stimulus: start held high during FILL, DRAIN and CLEAR.
  - Response: len and dir are not re-latched; the new frame begins only from IDLE.
